// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider, configurable frame format and a
// small input FIFO. Frames are sent back to back while the FIFO has data.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk_s,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 full,
  output logic                 overrun,
  output logic                 tx,
  output logic                 led_tx
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);
  localparam logic            OddPar   = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 overrun_q;
  logic                 push, pop, fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  // Transmit FSM state
  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  // full reflects the count before the edge, so a write while full is dropped
  // even when a pop happens on the same edge.
  assign full          = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = send & ~full;
  assign head          = mem[rd_ptr_q];

  // FIFO storage write
  always_ff @(posedge clk_s) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  // FIFO pointers, occupancy count and overrun pulse
  always_ff @(posedge clk_s) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= send & full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_s) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx is registered so each value is set on the edge that
  // enters its bit slot.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    bit_end   = (div_q == DivLast);
    if (state_q != StIdle) div_d = bit_end ? '0 : div_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = StStart;
          div_d   = '0;
          shift_d = head;
          par_d   = (^head) ^ OddPar;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = StPar;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StPar: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (fifo_nonempty) begin
              pop     = 1'b1;
              state_d = StStart;
              div_d   = '0;
              shift_d = head;
              par_d   = (^head) ^ OddPar;
              tx_d    = 1'b0;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx      = tx_q;
  assign overrun = overrun_q;
  assign led_tx  = (state_q != StIdle);
  assign busy    = fifo_nonempty | (state_q != StIdle);

endmodule
